// File: rtl/stream_pkg.sv
// stream_pkg
//   Shared definitions for the valid/ready stream traffic blocks
//   (ramp source today, matching ramp checker later).
//   Contents:
//     stream_state_t : run-state encoding shared by source and sink.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } stream_state_t;

endpackage

// File: rtl/stream_ramp_src.sv
// stream_ramp_src
//   Valid/ready stream transmitter that emits an arithmetic ramp
//   (seed, seed+step, seed+2*step, ...) for a programmed number of beats,
//   optionally inserting idle (valid-low) cycles after every accepted beat.
//   All outputs are registered; nothing depends combinationally on ready.
//
//   Ports:
//     i_clock       in   system clock, rising edge
//     i_reset       in   synchronous active-high reset
//     i_start       in   one-cycle run request, honoured only when idle
//     i_seed        in   first ramp value (latched at start)
//     i_step        in   per-beat increment (latched at start)
//     i_count       in   number of beats to send (latched at start)
//     i_gap         in   idle cycles after each accepted beat (latched at start)
//     o_out_data    out  stream data
//     o_out_valid   out  stream valid
//     i_out_ready   in   downstream ready
//     o_busy        out  high from the cycle after start through the done pulse
//     o_done        out  one-cycle pulse once the run has finished
//     o_beat_count  out  beats accepted in the current/last run
module stream_ramp_src
  import stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_step,
  input  logic [CNT_W-1:0] i_count,
  input  logic [GAP_W-1:0] i_gap,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_beat_count
);

  stream_state_t    state;
  logic [WIDTH-1:0] step_q;
  logic [CNT_W-1:0] count_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] beat_next;

  assign beat_next = beat_q + CNT_W'(1);

  // Single-process FSM with registered outputs.
  // SEND is entered from IDLE with valid still low: the first cycle in SEND
  // is a load cycle that raises valid, so the first beat appears two edges
  // after start is sampled. A zero-length run mirrors that latency by
  // spending one cycle in DONE before pulsing o_done. Returning from GAP
  // raises valid directly, so the idle stretch is exactly gap cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      step_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            step_q  <= i_step;
            count_q <= i_count;
            gap_q   <= i_gap;
            data_q  <= i_seed;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state   <= (i_count == '0) ? ST_DONE : ST_SEND;
          end
        end

        ST_SEND: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (i_out_ready) begin
            beat_q <= beat_next;
            if (beat_next == count_q) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              data_q <= data_q + step_q;
              if (gap_q != '0) begin
                valid_q <= 1'b0;
                gap_cnt <= gap_q;
                state   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            valid_q <= 1'b1;
            state   <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_DONE: begin
          if (done_q) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_out_data   = data_q;
  assign o_out_valid  = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_beat_count = beat_q;

endmodule

// File: tb/tb_stream_ramp_src.sv
// tb_stream_ramp_src
//   Self-checking bench for stream_ramp_src. A negedge monitor records every
//   accepted beat (data and cycle number) and flags any stalled beat that
//   changes or drops; each test pushes the expected ramp into a queue when
//   it starts a run and pops/compares it against the recorded beats.
module tb_stream_ramp_src;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int GAP_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] seed  = '0;
  logic [WIDTH-1:0] step  = '0;
  logic [CNT_W-1:0] count = '0;
  logic [GAP_W-1:0] gap   = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] beat_count;

  int assertions = 0;
  int failures   = 0;

  int cyc = 0;
  int stall_errs = 0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] obs_q[$];
  int               cyc_q[$];
  logic [WIDTH-1:0] exp_q[$];

  stream_ramp_src #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_start      (start),
    .i_seed       (seed),
    .i_step       (step),
    .i_count      (count),
    .i_gap        (gap),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_beat_count (beat_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Inputs change 1ns after the rising edge, so the values seen at the
  // falling edge are the ones the next rising edge will sample.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data))
        stall_errs <= stall_errs + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] st,
                           input logic [CNT_W-1:0] c, input logic [GAP_W-1:0] g);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < int'(c); i++) begin
      exp_q.push_back(v);
      v = v + st;
    end
    seed  = s;
    step  = st;
    count = c;
    gap   = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    assertions++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== '0 || beat_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid=%0b busy=%0b done=%0b data=%0h beats=%0d, required all zero",
               out_valid, busy, done, out_data, beat_count);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int base; bit seen; int at;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    out_ready = 1'b1;
    start_run(16'd0, 16'd1, 16'd8, 8'd0);
    @(negedge clock);
    assertions++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_first_cycle: busy=%0b valid=%0b, required busy=1 valid=0", busy, out_valid);
    end
    wait_done(40, seen, at);
    assertions++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL b2b_timeout: done not seen, required within 40 cycles");
    end
    assertions++;
    if (obs_q.size() - base != 8) begin
      failures++;
      $display("[TB] FAIL b2b_beats: got %0d transfers, required 8", obs_q.size() - base);
    end
    for (int i = 0; i < 8 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL b2b_data[%0d]: got %0h, required %0h", i, obs_q[base+i], e);
      end
      if (i > 0) begin
        assertions++;
        if (cyc_q[base+i] - cyc_q[base+i-1] != 1) begin
          failures++;
          $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles, required 1", i, cyc_q[base+i] - cyc_q[base+i-1]);
        end
      end
    end
    exp_q.delete();
    if (obs_q.size() > base) begin
      assertions++;
      if (at != cyc_q[obs_q.size()-1] + 1) begin
        failures++;
        $display("[TB] FAIL b2b_done_timing: done at cycle %0d, required %0d", at, cyc_q[obs_q.size()-1] + 1);
      end
    end
    assertions++;
    if (beat_count !== 16'd8 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_final: beats=%0d busy=%0b, required beats=8 busy=1", beat_count, busy);
    end
    tick();
    @(negedge clock);
    assertions++;
    if (busy !== 1'b0 || done !== 1'b0 || beat_count !== 16'd8) begin
      failures++;
      $display("[TB] FAIL b2b_idle: busy=%0b done=%0b beats=%0d, required 0 0 8", busy, done, beat_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int base; int held; bit seen; int at;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    held = 0;
    out_ready = 1'b0;
    start_run(16'd0, 16'd2, 16'd4, 8'd0);
    @(negedge clock);
    assertions++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_latency: valid=%0b one cycle after start, required 0", out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1 && out_data === 16'd0) held++;
    end
    assertions++;
    if (held != 20) begin
      failures++;
      $display("[TB] FAIL bp_hold: valid with data 0 on %0d cycles, required 20", held);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_done(20, seen, at);
    assertions++;
    if (!seen || obs_q.size() - base != 4) begin
      failures++;
      $display("[TB] FAIL bp_beats: done=%0b transfers=%0d, required done=1 transfers=4", seen, obs_q.size() - base);
    end
    for (int i = 0; i < 4 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e || (i > 0 && cyc_q[base+i] - cyc_q[base+i-1] != 1)) begin
        failures++;
        $display("[TB] FAIL bp_data[%0d]: got %0h, required %0h back-to-back", i, obs_q[base+i], e);
      end
    end
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic test_ready_toggle();
    int base; bit seen; int at; int ph;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    seen = 1'b0;
    out_ready = 1'b0;
    start_run(16'd0, 16'd3, 16'd16, 8'd0);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clock);
      #1;
      ph = k % 14;
      out_ready = (ph < 2) || (ph >= 5 && ph < 9);
      // A start and new parameters mid-run must have no effect.
      start = (k == 3);
      if (k == 3) begin
        seed  = 16'hAAAA;
        step  = 16'h1111;
        count = 16'd1;
        gap   = 8'd5;
      end
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    assertions++;
    if (!seen || obs_q.size() - base != 16) begin
      failures++;
      $display("[TB] FAIL toggle_beats: done=%0b transfers=%0d, required done=1 transfers=16", seen, obs_q.size() - base);
    end
    for (int i = 0; i < 16 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL toggle_data[%0d]: got %0h, required %0h", i, obs_q[base+i], e);
      end
    end
    exp_q.delete();
    assertions++;
    if (beat_count !== 16'd16) begin
      failures++;
      $display("[TB] FAIL toggle_count: beats=%0d, required 16", beat_count);
    end
    assertions++;
    if (stall_errs != 0) begin
      failures++;
      $display("[TB] FAIL stall_stability: %0d stalled beats changed or dropped, required 0", stall_errs);
    end
    tick();
    tick();
  endtask

  task automatic test_gap();
    int base; bit seen; int at;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    out_ready = 1'b1;
    start_run(16'd10, 16'd5, 16'd5, 8'd3);
    wait_done(60, seen, at);
    assertions++;
    if (!seen || obs_q.size() - base != 5) begin
      failures++;
      $display("[TB] FAIL gap_beats: done=%0b transfers=%0d, required done=1 transfers=5", seen, obs_q.size() - base);
    end
    for (int i = 0; i < 5 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL gap_data[%0d]: got %0d, required %0d", i, obs_q[base+i], e);
      end
      if (i > 0) begin
        assertions++;
        if (cyc_q[base+i] - cyc_q[base+i-1] != 4) begin
          failures++;
          $display("[TB] FAIL gap_spacing[%0d]: beats %0d cycles apart, required 4", i, cyc_q[base+i] - cyc_q[base+i-1]);
        end
      end
    end
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic test_wrap_and_zero();
    int base; bit seen; int at; bit any_valid;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    out_ready = 1'b1;
    start_run(16'hFFFE, 16'd1, 16'd4, 8'd0);
    wait_done(30, seen, at);
    assertions++;
    if (!seen || obs_q.size() - base != 4) begin
      failures++;
      $display("[TB] FAIL wrap_beats: done=%0b transfers=%0d, required done=1 transfers=4", seen, obs_q.size() - base);
    end
    for (int i = 0; i < 4 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL wrap_data[%0d]: got %0h, required %0h", i, obs_q[base+i], e);
      end
    end
    exp_q.delete();
    tick();
    tick();

    base = obs_q.size();
    any_valid = 1'b0;
    start_run(16'h1234, 16'd1, 16'd0, 8'd0);
    @(negedge clock);
    any_valid |= out_valid;
    assertions++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_early: done=%0b busy=%0b one cycle after start, required 0 1", done, busy);
    end
    @(negedge clock);
    any_valid |= out_valid;
    assertions++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_done: done=%0b busy=%0b two cycles after start, required 1 1", done, busy);
    end
    @(negedge clock);
    any_valid |= out_valid;
    assertions++;
    if (done !== 1'b0 || busy !== 1'b0 || beat_count !== '0) begin
      failures++;
      $display("[TB] FAIL zero_after: done=%0b busy=%0b beats=%0d, required 0 0 0", done, busy, beat_count);
    end
    assertions++;
    if (any_valid || obs_q.size() != base) begin
      failures++;
      $display("[TB] FAIL zero_no_beats: valid seen=%0b transfers=%0d, required 0 0", any_valid, obs_q.size() - base);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int base; int n; bit seen; int at;
    logic [WIDTH-1:0] e;
    base = obs_q.size();
    out_ready = 1'b1;
    start_run(16'd7, 16'd1, 16'd100, 8'd0);
    for (int i = 0; i < 6; i++) tick();
    seed  = 16'h5555;
    count = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    assertions++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || beat_count !== '0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_reset: valid=%0b busy=%0b beats=%0d done=%0b, required all zero",
               out_valid, busy, beat_count, done);
    end
    n = obs_q.size() - base;
    assertions++;
    if (n < 5) begin
      failures++;
      $display("[TB] FAIL midrun_progress: %0d beats before reset, required at least 5", n);
    end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL midrun_data[%0d]: got %0h, required %0h", i, obs_q[base+i], e);
      end
    end
    exp_q.delete();
    for (int i = 0; i < 5; i++) tick();
    assertions++;
    if (obs_q.size() - base != n) begin
      failures++;
      $display("[TB] FAIL midrun_aborted: %0d beats after reset, required 0", obs_q.size() - base - n);
    end

    base = obs_q.size();
    out_ready = 1'b1;
    start_run(16'h0100, 16'd1, 16'd3, 8'd0);
    wait_done(20, seen, at);
    assertions++;
    if (!seen || obs_q.size() - base != 3 || beat_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL restart_beats: done=%0b transfers=%0d beats=%0d, required 1 3 3",
               seen, obs_q.size() - base, beat_count);
    end
    for (int i = 0; i < 3 && base + i < obs_q.size(); i++) begin
      e = exp_q.pop_front();
      assertions++;
      if (obs_q[base+i] !== e) begin
        failures++;
        $display("[TB] FAIL restart_data[%0d]: got %0h, required %0h", i, obs_q[base+i], e);
      end
    end
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_ready_toggle();
    test_gap();
    test_wrap_and_zero();
    test_reset_midrun();
    assertions++;
    if (stall_errs != 0) begin
      failures++;
      $display("[TB] FAIL stall_stability_final: %0d stalled beats changed or dropped, required 0", stall_errs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/stream_ramp_src.md
Name: stream_ramp_src

Overview:
Synthesizable valid/ready stream transmitter that emits a programmable arithmetic ramp (seed, seed+step, seed+2*step, ...) for a programmed beat count. It is the upstream end of the skid buffer and other valid/ready stream blocks. It drives the same in-data/valid/ready interface the skid consumes and serves as an on-chip traffic source for bring-up and loopback tests. Optional idle gaps between beats exercise bursty-valid behaviour downstream.

Parameters:
WIDTH, 16, data width and ramp arithmetic width.
CNT_W, 16, width of beat count and beat counter.
GAP_W, 8, width of inter-beat idle-gap field.

Ports:
i_clock  in  1  system clock, all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  one-cycle request to begin a ramp; sampled only in IDLE.
i_seed  in  WIDTH  first data value, latched at start.
i_step  in  WIDTH  increment per beat, latched at start.
i_count  in  CNT_W  number of beats to send, latched at start.
i_gap  in  GAP_W  idle cycles (valid low) inserted after each accepted beat, latched at start.
o_out_data  out  WIDTH  stream data.
o_out_valid  out  1  stream valid.
i_out_ready  in  1  downstream ready.
o_busy  out  1  high from the cycle after start until the done pulse, inclusive.
o_done  out  1  one-cycle pulse after the last beat is accepted.
o_beat_count  out  CNT_W  beats accepted so far in the current/last run.

Behaviour:
- Reset (synchronous, active-high, one clock; i_clock and i_reset as named above): state=IDLE, o_out_valid=0, o_out_data=0, o_busy=0, o_done=0, o_beat_count=0. Reset mid-run aborts immediately; no further beats. A beat presented but not yet accepted is dropped.
- States: IDLE, SEND, GAP, DONE.
- IDLE: on i_start, latch seed/step/count/gap and clear o_beat_count.
  - count!=0: go to SEND. Data register=seed.
  - count==0: go to DONE. No beat is ever sent.
  - o_out_valid stays low in IDLE.
- SEND: o_out_valid=1. Latency: start sampled at edge N gives valid=1 and data=seed after edge N+1.
- Handshake: a beat transfers on a rising edge with o_out_valid & i_out_ready. While valid is high and ready is low, o_out_data and o_out_valid hold stable. Valid never drops without a transfer.
- On transfer:
  - o_beat_count increments.
  - If this was beat count-1 (last), go to DONE.
  - Otherwise data += step, modulo 2^WIDTH (wraps silently, no saturation).
  - Then: gap==0 stays in SEND, valid remains 1 (back-to-back, one beat/cycle under constant ready). gap>0 goes to GAP.
- GAP: valid=0 for exactly gap cycles, then SEND with the next value already loaded. i_out_ready is ignored in GAP.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy drops with the IDLE transition. o_beat_count holds its final value until the next start.
- i_start while not IDLE is ignored; no queuing, no restart.
- Latched parameters are immune to input changes mid-run.
- Ready may be asserted before valid; there is no combinational path from i_out_ready to o_out_valid or o_out_data.

Decomposition:
- Shared package stream_pkg: state enum (IDLE, SEND, GAP, DONE) typedef. Reused later by a matching stream_ramp_chk sink.
- No sub-module needed. The gap down-counter and beat counter live inline.
- Fits in ~150-200 lines of RTL.

Test Plan:
1. seed=0, step=1, count=8, gap=0, ready=1 constant -> data 0..7 on 8 consecutive cycles; done pulse one cycle after beat 7; o_beat_count=8.
2. seed=0, step=2, count=4, ready held low 20 cycles, then high -> valid=1 with data=0 stable all 20 cycles; then 0,2,4,6 back-to-back; exactly 4 transfers.
3. seed=0, step=3, count=16, gap=0; ready toggling 2 high/3 low/4 high/5 low repeating -> data is the 0,3,6,...,45 sequence, no drops or duplicates; valid never falls before a transfer.
4. seed=10, step=5, count=5, gap=3, ready=1 -> beats 10,15,20,25,30, each separated by exactly 3 valid-low cycles; done after 30.
5. WIDTH=16, seed=0xFFFE, step=1, count=4 -> 0xFFFE, 0xFFFF, 0x0000, 0x0001; count=0 -> no valid ever, done pulses 2 cycles after start.
6. count=100 run, assert i_reset mid-stream with ready low -> next cycle valid=0, busy=0, beat_count=0. A new start during the run before reset is ignored; a fresh start after reset begins at seed.
